// File: rtl/pio_button_event_mailbox.sv
// Button event mailbox: synchronizes and debounces active-low keys, queues
// press/release events with a tick timestamp, and presents the queue head as
// a 32-bit status word for a host-polled input PIO. The host retires the head
// by toggling host_cmd[0] and flushes everything by toggling host_cmd[1].
module pio_button_event_mailbox #(
   parameter int unsigned NUM_BTN     = 4,
   parameter int unsigned TICK_CYCLES = 50000,
   parameter int unsigned DEB_SAMPLES = 4,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [31:0]        host_cmd,
   output logic [31:0]        inport_data,
   output logic               event_pending,
   output logic               overflow
);

   localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned AGR_W   = 4;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned TS_W    = 16;

   typedef struct packed {
      logic             edge_bit;
      logic [IDX_W-1:0] idx;
      logic [TS_W-1:0]  ts;
   } entry_t;

   logic [NUM_BTN-1:0] sync1_q;
   logic [NUM_BTN-1:0] sync2_q;
   logic [PRESC_W-1:0] presc_q;
   logic               tick_c;
   logic [TS_W-1:0]    ts_q;

   logic [NUM_BTN-1:0] deb_q;
   logic [AGR_W-1:0]   agr_q [NUM_BTN];
   logic [NUM_BTN-1:0] ev_edge_q;
   logic [TS_W-1:0]    ev_ts_q [NUM_BTN];
   logic [NUM_BTN-1:0] flip_c;
   logic [NUM_BTN-1:0] pending_q;

   logic               sel_valid_c;
   logic [NUM_BTN-1:0] sel_mask_c;
   entry_t             push_entry_c;

   entry_t             mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic [1:0]         prev_q;

   logic               ack_c;
   logic               clr_c;
   logic               full_c;
   logic               empty_c;
   logic               pop_c;
   logic               push_c;
   logic               drop_c;
   entry_t             head_c;
   logic [31:0]        word_c;

   logic               unused_host_bits;
   assign unused_host_bits = ^host_cmd[31:2];

   // Two-flop synchronizer; keys idle released (high)
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   assign tick_c = (presc_q == PRESC_W'(TICK_CYCLES - 1));

   // Sample-tick prescaler and free-running wrapping timestamp
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         presc_q <= '0;
         ts_q    <= '0;
      end else if (tick_c) begin
         presc_q <= '0;
         ts_q    <= ts_q + TS_W'(1);
      end else begin
         presc_q <= presc_q + PRESC_W'(1);
      end
   end

   // A button flips on the DEB_SAMPLES-th consecutive disagreeing tick
   always_comb begin
      flip_c = '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         flip_c[i] = tick_c && (sync2_q[i] != deb_q[i]) &&
                     (agr_q[i] == AGR_W'(DEB_SAMPLES - 1));
      end
   end

   // Debounce state, agree counters and per-button captured edge/timestamp
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         deb_q     <= '1;
         ev_edge_q <= '0;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            agr_q[i]   <= '0;
            ev_ts_q[i] <= '0;
         end
      end else if (tick_c) begin
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (sync2_q[i] != deb_q[i]) begin
               if (flip_c[i]) begin
                  deb_q[i]     <= sync2_q[i];
                  agr_q[i]     <= '0;
                  ev_edge_q[i] <= ~sync2_q[i];
                  ev_ts_q[i]   <= ts_q;
               end else begin
                  agr_q[i] <= agr_q[i] + AGR_W'(1);
               end
            end else begin
               agr_q[i] <= '0;
            end
         end
      end
   end

   // Lowest-index pending button wins the single push slot this cycle
   always_comb begin
      sel_valid_c  = 1'b0;
      sel_mask_c   = '0;
      push_entry_c = '0;
      for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_valid_c           = 1'b1;
            sel_mask_c            = '0;
            sel_mask_c[i]         = 1'b1;
            push_entry_c.edge_bit = ev_edge_q[i];
            push_entry_c.idx      = IDX_W'(i);
            push_entry_c.ts       = ev_ts_q[i];
         end
      end
   end

   // Host toggle detection and FIFO control; clear overrides push and pop
   always_comb begin
      ack_c   = host_cmd[0] ^ prev_q[0];
      clr_c   = host_cmd[1] ^ prev_q[1];
      full_c  = (cnt_q == CNT_W'(FIFO_DEPTH));
      empty_c = (cnt_q == '0);
      pop_c   = ack_c && !empty_c && !clr_c;
      push_c  = sel_valid_c && !clr_c && (!full_c || pop_c);
      drop_c  = sel_valid_c && !clr_c && full_c && !pop_c;
   end

   // Pending flags, FIFO pointers/occupancy, sticky overflow, host_cmd history
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pending_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         prev_q    <= 2'b00;
      end else begin
         prev_q <= host_cmd[1:0];
         if (clr_c) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
         end else begin
            pending_q <= (pending_q & ~sel_mask_c) | flip_c;
            if (push_c) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
            if (drop_c) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   // Event storage; contents are only exposed while the FIFO is non-empty
   always_ff @(posedge clk_clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= push_entry_c;
      end
   end

   always_comb begin
      head_c = mem_q[rd_ptr_q];
      word_c = {~empty_c, ovf_q, 4'(cnt_q), 5'd0,
                (empty_c ? 21'd0 : head_c)};
   end

   // Registered status word seen by the input PIO
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         inport_data <= '0;
      end else begin
         inport_data <= word_c;
      end
   end

   assign event_pending = inport_data[31];
   assign overflow      = inport_data[30];

endmodule

// File: tb/tb_pio_button_event_mailbox.sv
// Directed bench for pio_button_event_mailbox with TICK_CYCLES=4, DEB_SAMPLES=4.
// A press applied right after a tick-aligned edge A flips at edge A+16 and is
// visible on inport_data after edge A+18 with timestamp A/4+3.
module tb_pio_button_event_mailbox;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  btn = 4'hF;
   logic [31:0] host_cmd = 32'd0;
   logic [31:0] inport_data;
   logic        event_pending;
   logic        overflow;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   pio_button_event_mailbox #(
      .NUM_BTN(4), .TICK_CYCLES(4), .DEB_SAMPLES(4), .FIFO_DEPTH(8)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(rst_n),
      .btn_raw(btn),
      .host_cmd(host_cmd),
      .inport_data(inport_data),
      .event_pending(event_pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Edge counter: equals the number of rising edges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [31:0] mk_word(input logic ovf, input int cnt,
                                           input logic e, input int idx,
                                           input int ts);
      return {1'b1, ovf, 4'(cnt), 5'd0, e, 4'(idx), 16'(ts)};
   endfunction

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic align4();
      @(negedge clk);
      while (cyc % 4 != 0) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn = 4'hF; host_cmd = 32'd0;
      repeat (3) @(negedge clk);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL reset_word: got %h want 00000000", inport_data); end
      tests++; if (event_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", event_pending); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      rst_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         tests++;
         if ({inport_data, event_pending, overflow} !== 34'd0) begin
            fails++; $display("FAIL reset_idle cyc %0d: got %h/%b/%b want 0", cyc, inport_data, event_pending, overflow);
         end
      end
   endtask

   task automatic test_bounce();
      align4();
      for (int k = 0; k < 20; k++) begin
         btn[0] = ~btn[0];
         repeat (4) begin
            @(negedge clk);
            tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL bounce cyc %0d: got %h want 00000000", cyc, inport_data); end
         end
      end
      btn[0] = 1'b1;
      repeat (40) begin
         @(negedge clk);
         tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL bounce_hold cyc %0d: got %h want 00000000", cyc, inport_data); end
      end
   endtask

   task automatic test_single_press();
      int a;
      align4(); a = cyc; btn[2] = 1'b0;
      wait_cyc(a + 17);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL press_early: got %h want 00000000", inport_data); end
      wait_cyc(a + 18);
      tests++; if (inport_data !== mk_word(0, 1, 1, 2, a / 4 + 3)) begin fails++; $display("FAIL press_word: got %h want %h", inport_data, mk_word(0, 1, 1, 2, a / 4 + 3)); end
      tests++; if ({event_pending, overflow} !== 2'b10) begin fails++; $display("FAIL press_flags: got %b%b want 10", event_pending, overflow); end
      host_cmd[0] = ~host_cmd[0];
      wait_cyc(a + 19);
      tests++; if (inport_data !== mk_word(0, 1, 1, 2, a / 4 + 3)) begin fails++; $display("FAIL ack_pop_edge: got %h want %h", inport_data, mk_word(0, 1, 1, 2, a / 4 + 3)); end
      wait_cyc(a + 20);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL ack_empty_after: got %h want 00000000", inport_data); end
      align4(); a = cyc; btn[2] = 1'b1;
      wait_cyc(a + 18);
      tests++; if (inport_data !== mk_word(0, 1, 0, 2, a / 4 + 3)) begin fails++; $display("FAIL release_word: got %h want %h", inport_data, mk_word(0, 1, 0, 2, a / 4 + 3)); end
      host_cmd[0] = ~host_cmd[0];
      wait_cyc(a + 20);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL release_ack: got %h want 00000000", inport_data); end
   endtask

   task automatic test_simultaneous();
      int a;
      int ts;
      align4(); a = cyc; ts = a / 4 + 3; btn[3] = 1'b0; btn[1] = 1'b0;
      wait_cyc(a + 18);
      tests++; if (inport_data !== mk_word(0, 1, 1, 1, ts)) begin fails++; $display("FAIL simul_first: got %h want %h", inport_data, mk_word(0, 1, 1, 1, ts)); end
      wait_cyc(a + 19);
      tests++; if (inport_data !== mk_word(0, 2, 1, 1, ts)) begin fails++; $display("FAIL simul_count2: got %h want %h", inport_data, mk_word(0, 2, 1, 1, ts)); end
      host_cmd[0] = ~host_cmd[0];
      wait_cyc(a + 21);
      tests++; if (inport_data !== mk_word(0, 1, 1, 3, ts)) begin fails++; $display("FAIL simul_second: got %h want %h", inport_data, mk_word(0, 1, 1, 3, ts)); end
      host_cmd[0] = ~host_cmd[0];
      wait_cyc(a + 23);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL simul_drained: got %h want 00000000", inport_data); end
      align4(); a = cyc; ts = a / 4 + 3; btn[1] = 1'b1; btn[3] = 1'b1;
      wait_cyc(a + 19);
      tests++; if (inport_data !== mk_word(0, 2, 0, 1, ts)) begin fails++; $display("FAIL simul_release: got %h want %h", inport_data, mk_word(0, 2, 0, 1, ts)); end
      host_cmd[1] = ~host_cmd[1];
      wait_cyc(a + 20);
      tests++; if (inport_data !== mk_word(0, 2, 0, 1, ts)) begin fails++; $display("FAIL clear_edge: got %h want %h", inport_data, mk_word(0, 2, 0, 1, ts)); end
      wait_cyc(a + 21);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL clear_word: got %h want 00000000", inport_data); end
   endtask

   task automatic test_overflow();
      int a;
      int tsa;
      align4(); a = cyc; tsa = a / 4 + 3; btn = 4'h0;
      wait_cyc(a + 24);
      tests++; if (inport_data !== mk_word(0, 4, 1, 0, tsa)) begin fails++; $display("FAIL ovf_four: got %h want %h", inport_data, mk_word(0, 4, 1, 0, tsa)); end
      btn = 4'hF;
      wait_cyc(a + 48);
      tests++; if (inport_data !== mk_word(0, 8, 1, 0, tsa)) begin fails++; $display("FAIL ovf_full: got %h want %h", inport_data, mk_word(0, 8, 1, 0, tsa)); end
      btn = 4'hC;
      wait_cyc(a + 48 + 17);
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_before_drop: got %b want 0", overflow); end
      wait_cyc(a + 48 + 18);
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_after_drop: got %b want 1", overflow); end
      wait_cyc(a + 48 + 20);
      tests++; if (inport_data !== mk_word(1, 8, 1, 0, tsa)) begin fails++; $display("FAIL ovf_word: got %h want %h", inport_data, mk_word(1, 8, 1, 0, tsa)); end
      host_cmd[1] = ~host_cmd[1];
      wait_cyc(a + 48 + 22);
      tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL ovf_clear: got %h want 00000000", inport_data); end
   endtask

   task automatic test_ack_empty();
      host_cmd[0] = ~host_cmd[0];
      repeat (3) begin
         @(negedge clk);
         tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL ack_while_empty cyc %0d: got %h want 00000000", cyc, inport_data); end
      end
   endtask

   task automatic test_ack_push_full();
      int a;
      int ts1;
      align4(); a = cyc; ts1 = a / 4 + 3; btn = 4'hF;
      wait_cyc(a + 24); btn = 4'h0;
      wait_cyc(a + 48); btn = 4'hC;
      wait_cyc(a + 72);
      tests++; if (inport_data !== mk_word(0, 8, 0, 0, ts1)) begin fails++; $display("FAIL refill_full: got %h want %h", inport_data, mk_word(0, 8, 0, 0, ts1)); end
      a = a + 72; btn[0] = 1'b1;
      wait_cyc(a + 16);
      host_cmd[0] = ~host_cmd[0];
      wait_cyc(a + 17);
      tests++; if (inport_data !== mk_word(0, 8, 0, 0, ts1)) begin fails++; $display("FAIL pushpop_edge: got %h want %h", inport_data, mk_word(0, 8, 0, 0, ts1)); end
      wait_cyc(a + 18);
      tests++; if (inport_data !== mk_word(0, 8, 0, 1, ts1)) begin fails++; $display("FAIL pushpop_full: got %h want %h", inport_data, mk_word(0, 8, 0, 1, ts1)); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid();
      btn = 4'hF; host_cmd = 32'd0; rst_n = 1'b0;
      #1;
      tests++; if ({inport_data, event_pending, overflow} !== 34'd0) begin fails++; $display("FAIL mid_reset_async: got %h/%b/%b want 0", inport_data, event_pending, overflow); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         tests++; if (inport_data !== 32'h0) begin fails++; $display("FAIL mid_reset_after cyc %0d: got %h want 00000000", cyc, inport_data); end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_single_press();
      test_simultaneous();
      test_overflow();
      test_ack_empty();
      test_ack_push_full();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
